// File: rtl/masku_result_packer.sv
// Mask-result write packer: gathers LSB-first result bits into W-bit beats, shuffles each beat into
// the per-lane VRF byte layout and drains it over per-lane handshakes. MASKU_RESULT_PACKER_DBUF_EN
// selects a separate output register so accumulation overlaps draining.
module masku_result_packer #(
  parameter  int unsigned NrLanes = 4,
  localparam int unsigned ELEN    = 64,
  localparam int unsigned W       = NrLanes * ELEN,
  localparam int unsigned NB      = W / 8,
  localparam int unsigned CntW    = $clog2(W) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [31:0]                    vl_i,
  input  logic [1:0]                     vsew_i,
  output logic                           busy_o,
  output logic                           done_o,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [W-1:0]                   in_bits_i,
  input  logic [CntW-1:0]                in_cnt_i,
  output logic [NrLanes-1:0]             result_valid_o,
  input  logic [NrLanes-1:0]             result_ready_i,
  output logic [NrLanes-1:0][ELEN-1:0]   result_data_o,
  output logic [NrLanes-1:0][7:0]        result_be_o,
  output logic                           result_last_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  // Element e goes to lane e % NrLanes; its slot inside the lane word is the bit-reversed
  // in-lane element position, so that EEW changes only permute whole elements.
  function automatic int unsigned shuffle_index(int unsigned b, int unsigned lanes, logic [1:0] ew);
    int unsigned k, e, lane, p, pbits, rp;
    k     = b & ((32'd1 << ew) - 32'd1);
    e     = b >> ew;
    lane  = e % lanes;
    p     = e / lanes;
    pbits = 32'd3 - 32'(ew);
    rp    = 0;
    for (int unsigned i = 0; i < 3; i++)
      if (i < pbits) rp = rp | (((p >> i) & 32'd1) << (pbits - 32'd1 - i));
    return lane * 8 + (rp << ew) + k;
  endfunction

  function automatic logic [W-1:0] shuffle_data(logic [W-1:0] seq, logic [1:0] ew);
    logic [W-1:0] res;
    res = '0;
    for (int unsigned b = 0; b < NB; b++)
      res[8*shuffle_index(b, NrLanes, ew) +: 8] = seq[8*b +: 8];
    return res;
  endfunction

  function automatic logic [NB-1:0] beat_be(logic [CntW-1:0] cnt, logic [1:0] ew);
    logic [NB-1:0] res;
    res = '0;
    for (int unsigned b = 0; b < NB; b++)
      if (8 * b < 32'(cnt)) res[shuffle_index(b, NrLanes, ew)] = 1'b1;
    return res;
  endfunction

  function automatic logic [NrLanes-1:0] lane_mask(logic [NB-1:0] be);
    logic [NrLanes-1:0] res;
    for (int unsigned l = 0; l < NrLanes; l++) res[l] = |be[8*l +: 8];
    return res;
  endfunction

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [CntW-1:0]     ptr_q, ptr_d;
  logic [31:0]         rem_q, rem_d;
  logic                full_q, full_d;
  logic [1:0]          vsew_q, vsew_d;
  logic [NrLanes-1:0]  out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  logic                accept, fill_done, fill_last, out_free, last_drained;
  logic [CntW-1:0]     eff, fill_ptr;
  logic [W-1:0]        chunk_mask, fill_acc, out_seq;
  logic [31:0]         fill_rem;
  logic [NrLanes-1:0]  lanes_pending;
  logic [CntW-1:0]     out_cnt;

`ifdef MASKU_RESULT_PACKER_DBUF_EN
  logic                last_q, last_d;
  logic [W-1:0]        out_seq_q, out_seq_d;
  logic [CntW-1:0]     out_cnt_q, out_cnt_d;
  logic                beat_avail, beat_last;
  logic [W-1:0]        beat_seq;
  logic [CntW-1:0]     beat_cnt;

  assign out_seq    = out_seq_q;
  assign out_cnt    = out_cnt_q;
  assign beat_avail = full_q | (accept & fill_done);
  assign beat_seq   = full_q ? acc_q  : fill_acc;
  assign beat_cnt   = full_q ? ptr_q  : fill_ptr;
  assign beat_last  = full_q ? last_q : fill_last;
`else
  // Shared storage: the accumulator itself is presented to the lanes once complete.
  assign out_seq = acc_q;
  assign out_cnt = ptr_q;
`endif

  assign accept     = in_valid_i & in_ready_o;
  assign eff        = (32'(in_cnt_i) > rem_q) ? rem_q[CntW-1:0] : in_cnt_i;
  assign chunk_mask = (eff >= CntW'(W)) ? '1 : ((W'(1) << eff) - W'(1));
  assign fill_acc   = acc_q | ((in_bits_i & chunk_mask) << ptr_q);
  assign fill_ptr   = ptr_q + eff;
  assign fill_rem   = rem_q - 32'(eff);
  assign fill_last  = (fill_rem == 32'd0);
  assign fill_done  = (fill_ptr == CntW'(W)) || fill_last;

  assign lanes_pending = out_valid_q & ~result_ready_i;
  assign out_free      = (lanes_pending == '0);
  assign last_drained  = out_last_q && (out_valid_q != '0) && out_free;

  always_comb begin
    acc_d       = acc_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    full_d      = full_q;
    vsew_d      = vsew_q;
    out_valid_d = lanes_pending;
    out_last_d  = out_last_q;
`ifdef MASKU_RESULT_PACKER_DBUF_EN
    last_d      = last_q;
    out_seq_d   = out_seq_q;
    out_cnt_d   = out_cnt_q;
`endif
    if (state_q == IDLE && start_i) begin
      acc_d  = '0;
      ptr_d  = '0;
      rem_d  = vl_i;
      full_d = 1'b0;
      vsew_d = vsew_i;
    end else if (accept) begin
      acc_d = fill_acc;
      ptr_d = fill_ptr;
      rem_d = fill_rem;
      if (fill_done) full_d = 1'b1;
    end
`ifdef MASKU_RESULT_PACKER_DBUF_EN
    if (accept && fill_done) last_d = fill_last;
    if (beat_avail && out_free) begin
      out_seq_d   = beat_seq;
      out_cnt_d   = beat_cnt;
      out_valid_d = lane_mask(beat_be(beat_cnt, vsew_q));
      out_last_d  = beat_last;
      acc_d       = '0;
      ptr_d       = '0;
      full_d      = 1'b0;
      last_d      = 1'b0;
    end else if (out_free) begin
      out_last_d = 1'b0;
    end
`else
    if (accept && fill_done) begin
      out_valid_d = lane_mask(beat_be(fill_ptr, vsew_q));
      out_last_d  = fill_last;
    end else if (full_q && out_free) begin
      acc_d      = '0;
      ptr_d      = '0;
      full_d     = 1'b0;
      out_last_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q       <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      full_q      <= 1'b0;
      vsew_q      <= '0;
      out_valid_q <= '0;
      out_last_q  <= 1'b0;
`ifdef MASKU_RESULT_PACKER_DBUF_EN
      last_q      <= 1'b0;
      out_seq_q   <= '0;
      out_cnt_q   <= '0;
`endif
    end else begin
      acc_q       <= acc_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      full_q      <= full_d;
      vsew_q      <= vsew_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef MASKU_RESULT_PACKER_DBUF_EN
      last_q      <= last_d;
      out_seq_q   <= out_seq_d;
      out_cnt_q   <= out_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        if (vl_i == 32'd0) done_d = 1'b1;
        else               state_d = ACCUM;
      end
      ACCUM: if (accept && fill_last) state_d = DRAIN;
      DRAIN: if (last_drained) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != IDLE);
    done_o         = done_q;
    in_ready_o     = (state_q == ACCUM) && !full_q;
    result_valid_o = out_valid_q;
    result_last_o  = out_last_q;
    result_data_o  = shuffle_data(out_seq, vsew_q);
    result_be_o    = beat_be(out_cnt, vsew_q);
  end

  // Chunks must tile the beat exactly.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    accept |-> (in_cnt_i != '0) && ((W % 32'(in_cnt_i)) == 0));

endmodule

// File: tb/tb_masku_result_packer.sv
// Directed bench for masku_result_packer (NrLanes=4, W=256); works with or without
// MASKU_RESULT_PACKER_DBUF_EN.
module tb_masku_result_packer;
  localparam int W = 256;

  logic            clk, rst_n, start, in_valid, in_ready, busy, done, last;
  logic [31:0]     vl;
  logic [1:0]      vsew;
  logic [W-1:0]    in_bits;
  logic [8:0]      in_cnt;
  logic [3:0]      res_valid, res_ready;
  logic [3:0][63:0] res_data;
  logic [3:0][7:0] res_be;
  logic [W-1:0]    data_flat;
  logic [31:0]     be_flat;
  logic [W-1:0]    pat_a, pat_b, tmp;
  bit              acc_now;
  int              checks = 0;
  int              failures = 0;

  assign data_flat = res_data;
  assign be_flat   = res_be;

  masku_result_packer #(.NrLanes(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .vl_i(vl), .vsew_i(vsew),
    .busy_o(busy), .done_o(done), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_bits_i(in_bits), .in_cnt_i(in_cnt), .result_valid_o(res_valid),
    .result_ready_i(res_ready), .result_data_o(res_data), .result_be_o(res_be),
    .result_last_o(last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_instr(input logic [31:0] n, input logic [1:0] ew);
    start = 1'b1; vl = n; vsew = ew;
    step();
    start = 1'b0;
  endtask

  task automatic send_chunk(input string tag, input logic [W-1:0] bits, input logic [8:0] cnt);
    in_valid = 1'b1; in_bits = bits; in_cnt = cnt;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    check({tag, "_ready"}, W'(in_ready), W'(1'b1));
    step();
    in_valid = 1'b0;
    $display("chunk %s cnt=%0d sent", tag, cnt);
  endtask

  initial begin
    rst_n = 1'b1; start = 0; vl = 0; vsew = 0; in_valid = 0; in_bits = '0; in_cnt = '0; res_ready = '0;
    pat_a = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, 64'h8796A5B4C3D2E1F0};
    pat_b = ~pat_a;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", W'(in_ready), W'(0));
    check("rst_valid", W'(res_valid), W'(0));
    check("rst_data", data_flat, W'(0));
    check("rst_be", W'(be_flat), W'(0));
    check("rst_last", W'(last), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // EW8, vl=256, one full all-ones chunk
    begin_instr(256, 2'd0);
    check("t1_busy", W'(busy), W'(1));
    send_chunk("t1", '1, 9'd256);
    check("t1_valid", W'(res_valid), W'(4'hF));
    check("t1_be", W'(be_flat), W'(32'hFFFF_FFFF));
    check("t1_data", data_flat, {W{1'b1}});
    check("t1_last", W'(last), W'(1));
    res_ready = 4'hF;
    step();
    res_ready = 4'h0;
    check("t1_done", W'(done), W'(1));
    check("t1_busy_fall", W'(busy), W'(0));
    check("t1_valid_off", W'(res_valid), W'(0));
    step();
    check("t1_done_pulse", W'(done), W'(0));

    // EW8, vl=20, 32-bit chunk: partial last byte, lane 3 idle
    begin_instr(20, 2'd0);
    send_chunk("t2", W'(32'hFFFF_FFFF), 9'd32);
    check("t2_valid", W'(res_valid), W'(4'b0111));
    check("t2_be", W'(be_flat), W'(32'h0001_0101));
    check("t2_data", data_flat, {64'h0, 64'h0F, 64'hFF, 64'hFF});
    check("t2_last", W'(last), W'(1));
    res_ready = 4'b0001;
    step();
    check("t2_lane0_drop", W'(res_valid), W'(4'b0110));
    check("t2_no_done", W'(done), W'(0));
    res_ready = 4'b0110;
    step();
    res_ready = 4'h0;
    check("t2_valid_off", W'(res_valid), W'(0));
    check("t2_done", W'(done), W'(1));

    // EW64, vl=512, beats A and B, lane 1 stalled for 5 cycles
    begin_instr(512, 2'd3);
    send_chunk("t3a", pat_a, 9'd256);
    check("t3_a_valid", W'(res_valid), W'(4'hF));
    check("t3_a_data", data_flat, pat_a);
    check("t3_a_last", W'(last), W'(0));
    in_valid = 1'b1; in_bits = pat_b; in_cnt = 9'd256; res_ready = 4'b1101;
`ifdef MASKU_RESULT_PACKER_DBUF_EN
    check("t3_b_ready_dbuf", W'(in_ready), W'(1));
`else
    check("t3_b_ready_shared", W'(in_ready), W'(0));
`endif
    for (int i = 0; i < 5; i++) begin
      acc_now = in_valid && in_ready;
      step();
      if (acc_now) in_valid = 1'b0;
      check("t3_hold_valid", W'(res_valid), W'(4'b0010));
      check("t3_hold_data1", W'(res_data[1]), W'(pat_a[127:64]));
    end
    check("t3_hold_ready", W'(in_ready), W'(0));
    res_ready = 4'hF;
    acc_now = in_valid && in_ready;
    step();
    if (acc_now) in_valid = 1'b0;
    res_ready = 4'h0;
`ifdef MASKU_RESULT_PACKER_DBUF_EN
    check("t3_b_nobubble", W'(res_valid), W'(4'hF));
`else
    check("t3_b_gap", W'(res_valid), W'(0));
`endif
    for (int i = 0; i < 20 && res_valid != 4'hF; i++) begin
      acc_now = in_valid && in_ready;
      step();
      if (acc_now) in_valid = 1'b0;
    end
    check("t3_b_valid", W'(res_valid), W'(4'hF));
    check("t3_b_data", data_flat, pat_b);
    check("t3_b_last", W'(last), W'(1));
    check("t3_b_be", W'(be_flat), W'(32'hFFFF_FFFF));
    res_ready = 4'hF;
    step();
    res_ready = 4'h0;
    check("t3_done", W'(done), W'(1));
    check("t3_valid_off", W'(res_valid), W'(0));

    // vl=0: immediate done, never any valid
    begin_instr(0, 2'd0);
    check("t4_done", W'(done), W'(1));
    check("t4_busy", W'(busy), W'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_valid", W'(res_valid), W'(0));
    end
    check("t4_done_pulse", W'(done), W'(0));

    // reset while a full beat is presented
    begin_instr(256, 2'd0);
    send_chunk("t5", '1, 9'd256);
    check("t5_valid_pre", W'(res_valid), W'(4'hF));
    rst_n = 1'b0;
    #1;
    check("t5_valid", W'(res_valid), W'(0));
    check("t5_data", data_flat, W'(0));
    check("t5_be", W'(be_flat), W'(0));
    check("t5_last", W'(last), W'(0));
    check("t5_busy", W'(busy), W'(0));
    check("t5_ready", W'(in_ready), W'(0));
    #2 rst_n = 1'b1;
    step();

    // EW32 shuffle after reset
    for (int e = 0; e < 8; e++) tmp[32*e +: 32] = 32'h0101_0101 * 32'(e + 1);
    begin_instr(256, 2'd2);
    send_chunk("t6", tmp, 9'd256);
    check("t6_valid", W'(res_valid), W'(4'hF));
    check("t6_data", data_flat, {64'h08080808_04040404, 64'h07070707_03030303,
                                 64'h06060606_02020202, 64'h05050505_01010101});
    res_ready = 4'hF;
    step();
    res_ready = 4'h0;
    check("t6_done", W'(done), W'(1));

    // EW8 byte-index beat built from eight 32-bit chunks
    begin_instr(256, 2'd0);
    for (int i = 0; i < 8; i++) begin
      tmp = '0;
      tmp[31:0] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      send_chunk("t7", tmp, 9'd32);
    end
    check("t7_valid", W'(res_valid), W'(4'hF));
    check("t7_data", data_flat, {64'h1F0F1707_1B0B1303, 64'h1E0E1606_1A0A1202,
                                 64'h1D0D1505_19091101, 64'h1C0C1404_18081000});
    res_ready = 4'hF;
    step();
    res_ready = 4'h0;
    check("t7_done", W'(done), W'(1));

    // start while busy is ignored: vl=16 EW64 stays in force
    begin_instr(16, 2'd3);
    check("t8_busy", W'(busy), W'(1));
    begin_instr(256, 2'd0);
    send_chunk("t8", '1, 9'd256);
    check("t8_valid", W'(res_valid), W'(4'b0001));
    check("t8_be", W'(be_flat), W'(32'h0000_0003));
    check("t8_data", data_flat, W'(16'hFFFF));
    check("t8_last", W'(last), W'(1));
    res_ready = 4'b0001;
    step();
    res_ready = 4'h0;
    check("t8_done", W'(done), W'(1));
    check("t8_busy_fall", W'(busy), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
